// File: rtl/mc_main_control.sv
// Multicycle main control FSM for the MIPS-subset datapath.
// Drives PC/IR/memory/register-file strobes and ALUOp; memory accesses stall on mem_ready.
//
// state  | meaning
// IDLE   | post-reset, all outputs 0
// FETCH  | read instruction at PC, PC += 4 when memory is ready
// DECODE | register read, branch target precompute, opcode dispatch
// MEMADR | effective address for lw/sw
// MEMRD  | data memory read (waits for mem_ready)
// MEMWB  | load write-back from MDR
// MEMWR  | data memory write (waits for mem_ready)
// EXEC   | R-type ALU operation
// ALUWB  | R-type write-back to rd
// BRANCH | beq compare and conditional PC load
// ADDIEX | addi ALU operation
// ADDIWB | addi write-back to rt
// JUMP   | PC load from jump target
module mc_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t cur_state;
    state_t next_state;
    logic   op_known;

    assign state = cur_state;
    assign op_known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= S_IDLE;
            illegal_op <= 1'b0;
        end else begin
            cur_state  <= next_state;
            illegal_op <= (cur_state == S_DECODE) && !op_known;
        end
    end

    always_comb begin
        next_state    = cur_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_op        = 4'b0000;
        case (cur_state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (op == OP_LW || op == OP_SW) next_state = S_MEMADR;
                else if (op == OP_RTYPE)        next_state = S_EXEC;
                else if (op == OP_BEQ)          next_state = S_BRANCH;
                else if (op == OP_ADDI)         next_state = S_ADDIEX;
                else if (op == OP_J)            next_state = S_JUMP;
                else                            next_state = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 4'b0010;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 4'b0001;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                next_state    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-instruction sequences, stalls, illegal op, reset.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_op, state;
    logic [22:0] all_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
    );

    assign all_out = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src,
                      alu_op, illegal_op, state};

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 6'b100011; mem_ready = 1'b1;
        step(); step();
        tests_run++;
        if (all_out !== 23'd0) begin
            tests_failed++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [7];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            tests_run++;
            if (state !== exp_st[i]) begin
                tests_failed++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            end
            if (exp_st[i] == 4'd1 || exp_st[i] == 4'd2 || exp_st[i] == 4'd3) begin
                tests_run++;
                if (alu_op !== 4'b0000) begin
                    tests_failed++; $display("FAIL lw_alu_op[%0d]: got %b want 0000", i, alu_op);
                end
            end
            tests_run++;
            if ((reg_write & mem_to_reg) !== (exp_st[i] == 4'd5)) begin
                tests_failed++;
                $display("FAIL lw_writeback[%0d]: got rw=%b m2r=%b want %b", i, reg_write, mem_to_reg, exp_st[i] == 4'd5);
            end
            if (exp_st[i] == 4'd1) begin
                tests_run++;
                if ({ir_write, pc_write, mem_read, alu_src_b} !== 5'b11101) begin
                    tests_failed++; $display("FAIL lw_fetch_strobes: got %b want 11101", {ir_write, pc_write, mem_read, alu_src_b});
                end
            end
        end
    endtask

    task automatic test_rtype();
        op = 6'b000000;
        step();
        tests_run++;
        if (state !== 4'd2 || alu_src_b !== 2'b11) begin
            tests_failed++; $display("FAIL rtype_decode: got st=%0d srcb=%b want 2/11", state, alu_src_b);
        end
        step();
        tests_run++;
        if ({state, alu_op, alu_src_a, alu_src_b} !== {4'd7, 4'b0010, 1'b1, 2'b00}) begin
            tests_failed++; $display("FAIL rtype_exec: got %b want 0111_0010_1_00", {state, alu_op, alu_src_a, alu_src_b});
        end
        step();
        tests_run++;
        if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd8, 3'b110}) begin
            tests_failed++; $display("FAIL rtype_wb: got %b want 1000_110", {state, reg_write, reg_dst, mem_to_reg});
        end
        step();
        tests_run++;
        if (state !== 4'd1) begin
            tests_failed++; $display("FAIL rtype_return: got %0d want 1", state);
        end
    endtask

    task automatic test_beq();
        op = 6'b000100;
        step(); step();
        tests_run++;
        if ({state, alu_op, pc_write_cond, pc_src, pc_write, alu_src_a} !== {4'd9, 4'b0001, 1'b1, 2'b01, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL beq_branch: got st=%0d aluop=%b pwc=%b psrc=%b pw=%b srca=%b want 9/0001/1/01/0/1",
                     state, alu_op, pc_write_cond, pc_src, pc_write, alu_src_a);
        end
        step();
        tests_run++;
        if (state !== 4'd1) begin
            tests_failed++; $display("FAIL beq_return: got %0d want 1", state);
        end
    endtask

    task automatic test_sw_stall();
        op = 6'b101011;
        step(); step();
        tests_run++;
        if ({state, alu_src_a, alu_src_b} !== {4'd3, 1'b1, 2'b10}) begin
            tests_failed++; $display("FAIL sw_memadr: got %b want 0011_1_10", {state, alu_src_a, alu_src_b});
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if ({state, mem_write, i_or_d, mem_read} !== {4'd6, 3'b110}) begin
                tests_failed++; $display("FAIL sw_memwr[%0d]: got %b want 0110_110", i, {state, mem_write, i_or_d, mem_read});
            end
            if (i == 3) mem_ready = 1'b1;
        end
        step();
        tests_run++;
        if (state !== 4'd1) begin
            tests_failed++; $display("FAIL sw_return: got %0d want 1", state);
        end
        // FETCH stall, then an addi through the stalled fetch
        mem_ready = 1'b0; op = 6'b001000;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            tests_run++;
            if ({state, ir_write, pc_write, mem_read} !== {4'd1, 3'b001}) begin
                tests_failed++; $display("FAIL fetch_stall[%0d]: got %b want 0001_001", i, {state, ir_write, pc_write, mem_read});
            end
        end
        mem_ready = 1'b1;
        #1;
        tests_run++;
        if ({ir_write, pc_write} !== 2'b11) begin
            tests_failed++; $display("FAIL fetch_release: got %b want 11", {ir_write, pc_write});
        end
        step(); step();
        tests_run++;
        if ({state, alu_src_a, alu_src_b, alu_op} !== {4'd10, 1'b1, 2'b10, 4'b0000}) begin
            tests_failed++; $display("FAIL addi_exec: got %b want 1010_1_10_0000", {state, alu_src_a, alu_src_b, alu_op});
        end
        step();
        tests_run++;
        if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd11, 3'b100}) begin
            tests_failed++; $display("FAIL addi_wb: got %b want 1011_100", {state, reg_write, reg_dst, mem_to_reg});
        end
        step();
        tests_run++;
        if (state !== 4'd1) begin
            tests_failed++; $display("FAIL addi_return: got %0d want 1", state);
        end
    endtask

    task automatic test_illegal();
        op = 6'b111111;
        step();
        tests_run++;
        if ({state, illegal_op, reg_write, mem_write, pc_write} !== {4'd2, 4'b0000}) begin
            tests_failed++; $display("FAIL illegal_decode: got %b want 0010_0000", {state, illegal_op, reg_write, mem_write, pc_write});
        end
        mem_ready = 1'b0;
        step();
        tests_run++;
        if ({state, illegal_op, reg_write, mem_write, pc_write} !== {4'd1, 4'b1000}) begin
            tests_failed++; $display("FAIL illegal_pulse: got %b want 0001_1000", {state, illegal_op, reg_write, mem_write, pc_write});
        end
        step();
        tests_run++;
        if ({state, illegal_op} !== {4'd1, 1'b0}) begin
            tests_failed++; $display("FAIL illegal_single: got %b want 0001_0", {state, illegal_op});
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_jump();
        op = 6'b000010;
        step(); step();
        tests_run++;
        if ({state, pc_write, pc_src, pc_write_cond} !== {4'd12, 1'b1, 2'b10, 1'b0}) begin
            tests_failed++; $display("FAIL jump: got %b want 1100_1_10_0", {state, pc_write, pc_src, pc_write_cond});
        end
        step();
        tests_run++;
        if (state !== 4'd1) begin
            tests_failed++; $display("FAIL jump_return: got %0d want 1", state);
        end
    endtask

    task automatic test_reset_mid();
        op = 6'b100011;
        step(); step();
        mem_ready = 1'b0;
        step();
        tests_run++;
        if ({state, mem_read, i_or_d} !== {4'd4, 2'b11}) begin
            tests_failed++; $display("FAIL memrd_wait: got %b want 0100_11", {state, mem_read, i_or_d});
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (all_out !== 23'd0) begin
            tests_failed++; $display("FAIL reset_mid: got %h want 0", all_out);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        tests_run++;
        if (state !== 4'd0) begin
            tests_failed++; $display("FAIL reset_idle: got %0d want 0", state);
        end
        step();
        tests_run++;
        if (state !== 4'd1) begin
            tests_failed++; $display("FAIL reset_fetch: got %0d want 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_stall();
        test_illegal();
        test_jump();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
